// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto one single-port memory, round-robin with bounded bursts.
// Latency: grant is combinational in the request cycle; read data returns RD_LATENCY cycles later.
// Backpressure: a requester holds req until gnt; a losing requester waits at most MAX_BURST cycles.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wd0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wd1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;
  logic [CW-1:0]         burst_q, burst_d;
  logic [CW-1:0]         burst_inc;
  // Return pipe: per stage a valid bit and the issuing port id (0/1).
  logic [RD_LATENCY-1:0] pv_q, pv_d;
  logic [RD_LATENCY-1:0] pid_q, pid_d;

  // State register: owner FSM, tie-break priority, burst counter, read-return pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      burst_q <= '0;
      pv_q    <= '0;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      burst_q <= burst_d;
      pv_q    <= pv_d;
      pid_q   <= pid_d;
    end
  end

  // Saturating increment so a lone requester cannot wrap the counter back below the limit.
  assign burst_inc = (burst_q == CW'(MAX_BURST)) ? burst_q : burst_q + CW'(1);

  // Next-state: ownership follows the grant; losing port gets the next tie from IDLE.
  always_comb begin
    state_d = IDLE;
    burst_d = '0;
    prio_d  = prio_q;
    if (gnt0) begin
      state_d = OWN0;
      prio_d  = 1'b1;
      burst_d = (state_q == OWN0) ? burst_inc : CW'(1);
    end else if (gnt1) begin
      state_d = OWN1;
      prio_d  = 1'b0;
      burst_d = (state_q == OWN1) ? burst_inc : CW'(1);
    end
  end

  // Output decode: grant selection; contention resolved by owner burst limit or prio from IDLE.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        case (state_q)
          OWN0: begin
            if (burst_q < CW'(MAX_BURST)) gnt0 = 1'b1;
            else                          gnt1 = 1'b1;
          end
          OWN1: begin
            if (burst_q < CW'(MAX_BURST)) gnt1 = 1'b1;
            else                          gnt0 = 1'b1;
          end
          default: begin
            if (prio_q) gnt1 = 1'b1;
            else        gnt0 = 1'b1;
          end
        endcase
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Memory drive: port 0 fields are the default mux leg, which also covers the idle case.
  assign mem_en   = gnt0 | gnt1;
  assign mem_we   = gnt1 ? we1 : (gnt0 & we0);
  assign mem_addr = gnt1 ? addr1 : addr0;
  assign mem_wd   = gnt1 ? wd1 : wd0;

  // Return pipe shift: granted reads enter stage 0 tagged with the issuer, writes enter empty.
  always_comb begin
    pv_d     = '0;
    pid_d    = '0;
    pv_d[0]  = mem_en & ~mem_we;
    pid_d[0] = gnt1;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pv_d[i]  = pv_q[i-1];
      pid_d[i] = pid_q[i-1];
    end
  end

  // Gate with reset so a read in flight when reset hits is never reported.
  assign rvalid0 = ~reset & pv_q[RD_LATENCY-1] & ~pid_q[RD_LATENCY-1];
  assign rvalid1 = ~reset & pv_q[RD_LATENCY-1] &  pid_q[RD_LATENCY-1];
  assign rdata0  = mem_rd;
  assign rdata1  = mem_rd;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle behavioural memory behind it.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wd0, addr1, wd1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  int errors = 0;
  int checks = 0;

  logic [31:0] tmem [0:255];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wd0(wd0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wd1(wd1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  // Behavioural single-port memory, read latency 1.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tmem[mem_addr[7:0]] <= mem_wd;
      else        mem_rd <= tmem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and checks happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tmem[i] = 32'h0;
    tmem[8'h10] = 32'h0000CAFE;
    tmem[8'h30] = 32'h0000AAAA;
    tmem[8'h40] = 32'h0000BBBB;
    mem_rd = '0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
    we0 = 1'b0; we1 = 1'b0;

    // 1: reset held 3 cycles with both requesting
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
      chk("rst_gnt1", {31'b0, gnt1}, 32'd0);
      chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
      step();
    end
    reset = 1'b0;
    idle();
    step();

    // 2: single port-0 read
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    #1;
    chk("rd0_gnt", {30'b0, gnt1, gnt0}, 32'b01);
    chk("rd0_mem_en", {31'b0, mem_en}, 32'd1);
    chk("rd0_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rd0_addr", mem_addr, 32'h10);
    step();
    idle();
    #1;
    chk("rd0_rvalid", {30'b0, rvalid1, rvalid0}, 32'b01);
    chk("rd0_rdata", rdata0, 32'h0000CAFE);
    step();
    chk("rd0_single", {30'b0, rvalid1, rvalid0}, 32'b00);

    // 4: port-1 write (also leaves prio pointing at port 0)
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wd1 = 32'h1234;
    #1;
    chk("wr1_gnt", {30'b0, gnt1, gnt0}, 32'b10);
    chk("wr1_mem_en", {31'b0, mem_en}, 32'd1);
    chk("wr1_mem_we", {31'b0, mem_we}, 32'd1);
    chk("wr1_addr", mem_addr, 32'h20);
    chk("wr1_wd", mem_wd, 32'h1234);
    step();
    idle();
    #1;
    chk("wr1_no_rvalid", {30'b0, rvalid1, rvalid0}, 32'b00);
    step();
    chk("wr1_mem", tmem[8'h20], 32'h1234);

    // 3: both requesting reads continuously from IDLE
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h30; addr1 = 32'h40;
    for (int c = 0; c < 12; c++) begin
      logic exp0;
      exp0 = ((c / 4) % 2) == 0;
      #1;
      chk($sformatf("burst_gnt[%0d]", c), {30'b0, gnt1, gnt0}, exp0 ? 32'b01 : 32'b10);
      if (c > 0) begin
        logic prev0;
        prev0 = (((c - 1) / 4) % 2) == 0;
        chk($sformatf("burst_rv[%0d]", c), {30'b0, rvalid1, rvalid0}, prev0 ? 32'b01 : 32'b10);
      end
      step();
    end
    idle();
    step();

    // 5: back-to-back reads port 0 then port 1
    req0 = 1'b1; addr0 = 32'h30;
    #1;
    chk("alt_gnt_a", {30'b0, gnt1, gnt0}, 32'b01);
    step();
    req0 = 1'b0; req1 = 1'b1; addr1 = 32'h40;
    #1;
    chk("alt_gnt_b", {30'b0, gnt1, gnt0}, 32'b10);
    chk("alt_rv_a", {30'b0, rvalid1, rvalid0}, 32'b01);
    chk("alt_rd_a", rdata0, 32'h0000AAAA);
    step();
    idle();
    #1;
    chk("alt_rv_b", {30'b0, rvalid1, rvalid0}, 32'b10);
    chk("alt_rd_b", rdata1, 32'h0000BBBB);
    step();

    // 6: reset one cycle after a read grant drops the read and clears FSM/prio
    req0 = 1'b1; addr0 = 32'h10;
    #1;
    chk("rr_gnt", {30'b0, gnt1, gnt0}, 32'b01);
    step();
    idle();
    reset = 1'b1;
    #1;
    chk("rr_rv_in_reset", {30'b0, rvalid1, rvalid0}, 32'b00);
    step();
    reset = 1'b0;
    #1;
    chk("rr_rv_after", {30'b0, rvalid1, rvalid0}, 32'b00);
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("rr_gnt[%0d]", c), {30'b0, gnt1, gnt0}, (c < 4) ? 32'b01 : 32'b10);
      step();
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
